// File: rtl/aes128_round_ctrl.sv
// ---------------------------------------------------------------------------
// aes128_round_ctrl
//
// Iterative AES-128 encrypt/decrypt sequencer. Drives an external
// combinational AES datapath (ARK/SUB/SHIFT/MIX) one operation per cycle,
// owns the 128-bit cipher state register and an 11-entry round-key file,
// expands the key on demand and hands the result out over valid/ready.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready
// are both high. in_ready is high only in IDLE; a request seen while busy is
// ignored and must be held by the producer. out_valid/out_data are held
// stable from DONE entry until the edge where out_ready is high.
//
// Ports
//   clk, clrn               clock, asynchronous active-low reset
//   in_valid/in_ready       request handshake
//   in_dec                  0 = encrypt, 1 = decrypt
//   in_key_load             force key expansion from in_key
//   in_key, in_data         key and input block, byte 0 at [7:0]
//   out_valid/out_ready     result handshake
//   out_data                result block
//   busy                    high in every state except IDLE
//   dp_ark/sub/shift/mix    one-hot datapath op select (0 when idle)
//   dp_inv                  inverse-op select (RND only)
//   dp_a                    {24'h0, rcon} during key expansion, else 0
//   dp_vb                   datapath operand
//   dp_vc                   datapath result (combinational from dp_*)
//   dbg_state               current FSM state encoding
// ---------------------------------------------------------------------------
module aes128_round_ctrl (
  input  logic         clk,
  input  logic         clrn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_dec,
  input  logic         in_key_load,
  input  logic [127:0] in_key,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy,
  output logic         dp_ark,
  output logic         dp_sub,
  output logic         dp_shift,
  output logic         dp_mix,
  output logic         dp_inv,
  output logic [31:0]  dp_a,
  output logic [127:0] dp_vb,
  input  logic [127:0] dp_vc,
  output logic [2:0]   dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_KEXP = 3'd1,
    S_INIT = 3'd2,
    S_RND  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t       r_state;
  logic [127:0] r_data;
  logic         r_dec;
  logic         r_key_valid;
  logic [3:0]   r_kidx;
  logic [3:0]   r_round;
  logic [1:0]   r_phase;
  logic         r_in_ready;
  logic         r_out_valid;
  logic [127:0] r_out_data;
  logic         r_busy;

  // Round-key file; contents deliberately not reset (key_valid guards use).
  logic [127:0] r_rk [0:10];

  logic         w_accept;
  logic         w_need_kexp;
  logic [7:0]   w_rcon;
  logic         w_rnd_last;
  logic         w_rnd_xor;
  logic         w_rnd_end;
  logic [127:0] w_rnd_val;
  logic         w_rk_we;
  logic [3:0]   w_rk_waddr;
  logic [127:0] w_rk_wdata;

  assign w_accept    = (r_state == S_IDLE) && in_valid && r_in_ready;
  assign w_need_kexp = in_key_load || !r_key_valid;

  always_comb begin
    w_rcon = 8'h00;
    case (r_kidx)
      4'd1:    w_rcon = 8'h01;
      4'd2:    w_rcon = 8'h02;
      4'd3:    w_rcon = 8'h04;
      4'd4:    w_rcon = 8'h08;
      4'd5:    w_rcon = 8'h10;
      4'd6:    w_rcon = 8'h20;
      4'd7:    w_rcon = 8'h40;
      4'd8:    w_rcon = 8'h80;
      4'd9:    w_rcon = 8'h1b;
      4'd10:   w_rcon = 8'h36;
      default: w_rcon = 8'h00;
    endcase
  end

  // Encrypt counts rounds 1..10, decrypt counts 9..0; the last round is the
  // two-phase one without MIX. In both directions the key to mix in is
  // rk[r_round], so the final rounds naturally pick rk[10] / rk[0].
  assign w_rnd_last = r_dec ? (r_round == 4'd0) : (r_round == 4'd10);
  assign w_rnd_end  = w_rnd_last ? (r_phase == 2'd1) : (r_phase == 2'd2);
  // Encrypt adds the key after MIX (or after SHIFT in the last round);
  // decrypt adds it after SUB, before InvMix.
  assign w_rnd_xor  = r_dec ? (r_phase == 2'd1) : w_rnd_end;
  assign w_rnd_val  = w_rnd_xor ? (dp_vc ^ r_rk[r_round]) : dp_vc;

  // Datapath controls: combinational decode of registered state/counters.
  always_comb begin
    dp_ark   = 1'b0;
    dp_sub   = 1'b0;
    dp_shift = 1'b0;
    dp_mix   = 1'b0;
    dp_inv   = 1'b0;
    dp_a     = 32'h0;
    dp_vb    = 128'h0;
    case (r_state)
      S_KEXP: begin
        dp_ark = 1'b1;
        dp_a   = {24'h0, w_rcon};
        dp_vb  = r_rk[r_kidx - 4'd1];
      end
      S_RND: begin
        dp_inv = r_dec;
        dp_vb  = r_data;
        case (r_phase)
          2'd0:    begin dp_sub   = !r_dec; dp_shift = r_dec;  end
          2'd1:    begin dp_shift = !r_dec; dp_sub   = r_dec;  end
          default: dp_mix = 1'b1;
        endcase
      end
      default: ;
    endcase
  end

  // Round-key file write port: rk[0] on an expanding accept, rk[i] in KEXP.
  always_comb begin
    w_rk_we    = 1'b0;
    w_rk_waddr = 4'd0;
    w_rk_wdata = in_key;
    if (w_accept && w_need_kexp) begin
      w_rk_we = 1'b1;
    end else if (r_state == S_KEXP) begin
      w_rk_we    = 1'b1;
      w_rk_waddr = r_kidx;
      w_rk_wdata = dp_vc;
    end
  end

  always_ff @(posedge clk) begin
    if (w_rk_we) begin
      r_rk[w_rk_waddr] <= w_rk_wdata;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state     <= S_IDLE;
      r_data      <= 128'h0;
      r_dec       <= 1'b0;
      r_key_valid <= 1'b0;
      r_kidx      <= 4'd0;
      r_round     <= 4'd0;
      r_phase     <= 2'd0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_data  <= 128'h0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_data     <= in_data;
            r_dec      <= in_dec;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            if (w_need_kexp) begin
              r_kidx  <= 4'd1;
              r_state <= S_KEXP;
            end else begin
              r_state <= S_INIT;
            end
          end
        end
        S_KEXP: begin
          if (r_kidx == 4'd10) begin
            r_key_valid <= 1'b1;
            r_kidx      <= 4'd0;
            r_state     <= S_INIT;
          end else begin
            r_kidx <= r_kidx + 4'd1;
          end
        end
        S_INIT: begin
          r_data  <= r_data ^ (r_dec ? r_rk[10] : r_rk[0]);
          r_round <= r_dec ? 4'd9 : 4'd1;
          r_phase <= 2'd0;
          r_state <= S_RND;
        end
        S_RND: begin
          r_data <= w_rnd_val;
          if (w_rnd_end) begin
            r_phase <= 2'd0;
            if (w_rnd_last) begin
              r_out_valid <= 1'b1;
              r_out_data  <= w_rnd_val;
              r_state     <= S_DONE;
            end else begin
              r_round <= r_dec ? (r_round - 4'd1) : (r_round + 4'd1);
            end
          end else begin
            r_phase <= r_phase + 2'd1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign busy      = r_busy;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_aes128_round_ctrl.sv
// ---------------------------------------------------------------------------
// tb_aes128_round_ctrl
//
// Bench for aes128_round_ctrl. Emulates the external combinational AES
// datapath, and checks results against a whole-block AES-128 reference
// (44-word key schedule, full cipher / inverse cipher) with a cached-key
// model deciding expected latency and which key is in effect.
// ---------------------------------------------------------------------------
module tb_aes128_round_ctrl;

  logic         clk;
  logic         clrn;
  logic         in_valid;
  logic         in_ready;
  logic         in_dec;
  logic         in_key_load;
  logic [127:0] in_key;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;
  logic         dp_ark, dp_sub, dp_shift, dp_mix, dp_inv;
  logic [31:0]  dp_a;
  logic [127:0] dp_vb;
  logic [127:0] dp_vc;
  logic [2:0]   dbg_state;

  aes128_round_ctrl dut (
    .clk(clk), .clrn(clrn),
    .in_valid(in_valid), .in_ready(in_ready), .in_dec(in_dec),
    .in_key_load(in_key_load), .in_key(in_key), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy),
    .dp_ark(dp_ark), .dp_sub(dp_sub), .dp_shift(dp_shift), .dp_mix(dp_mix),
    .dp_inv(dp_inv), .dp_a(dp_a), .dp_vb(dp_vb), .dp_vc(dp_vc),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [127:0] exp_q[$];
  logic [31:0]  ark_q[$];
  logic [31:0]  rcon_exp[$];
  int           op_cycles;
  logic         model_kv;
  logic [127:0] model_key;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // ---------------- AES primitives ----------------
  logic [7:0] sbox  [256];
  logic [7:0] isbox [256];

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00; x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sbox[x]  = s;
      isbox[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] sub_bytes(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    for (int k = 0; k < 16; k++)
      o[8*k +: 8] = inv ? isbox[s[8*k +: 8]] : sbox[s[8*k +: 8]];
    return o;
  endfunction

  // Byte k is row k%4, column k/4.
  function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!inv) o[8*(r+4*c) +: 8] = s[8*(r+4*((c+r)%4)) +: 8];
        else      o[8*(r+4*((c+r)%4)) +: 8] = s[8*(r+4*c) +: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_cols(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[32*c +: 8]; a1 = s[32*c+8 +: 8]; a2 = s[32*c+16 +: 8]; a3 = s[32*c+24 +: 8];
      if (!inv) begin
        o[32*c    +: 8] = gmul(a0,8'h02) ^ gmul(a1,8'h03) ^ a2 ^ a3;
        o[32*c+8  +: 8] = a0 ^ gmul(a1,8'h02) ^ gmul(a2,8'h03) ^ a3;
        o[32*c+16 +: 8] = a0 ^ a1 ^ gmul(a2,8'h02) ^ gmul(a3,8'h03);
        o[32*c+24 +: 8] = gmul(a0,8'h03) ^ a1 ^ a2 ^ gmul(a3,8'h02);
      end else begin
        o[32*c    +: 8] = gmul(a0,8'h0e) ^ gmul(a1,8'h0b) ^ gmul(a2,8'h0d) ^ gmul(a3,8'h09);
        o[32*c+8  +: 8] = gmul(a0,8'h09) ^ gmul(a1,8'h0e) ^ gmul(a2,8'h0b) ^ gmul(a3,8'h0d);
        o[32*c+16 +: 8] = gmul(a0,8'h0d) ^ gmul(a1,8'h09) ^ gmul(a2,8'h0e) ^ gmul(a3,8'h0b);
        o[32*c+24 +: 8] = gmul(a0,8'h0b) ^ gmul(a1,8'h0d) ^ gmul(a2,8'h09) ^ gmul(a3,8'h0e);
      end
    end
    return o;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  // One key-schedule step as the external datapath performs it for ARK.
  function automatic logic [127:0] key_step(input logic [127:0] p, input logic [7:0] rc);
    logic [31:0] t, n0, n1, n2, n3;
    t  = sub_word({p[103:96], p[127:104]}) ^ {24'h0, rc};
    n0 = p[31:0] ^ t; n1 = p[63:32] ^ n0; n2 = p[95:64] ^ n1; n3 = p[127:96] ^ n2;
    return {n3, n2, n1, n0};
  endfunction

  // Emulated combinational datapath unit.
  always_comb begin
    dp_vc = 128'h0;
    if (dp_ark)        dp_vc = key_step(dp_vb, dp_a[7:0]);
    else if (dp_sub)   dp_vc = sub_bytes(dp_vb, dp_inv);
    else if (dp_shift) dp_vc = shift_rows(dp_vb, dp_inv);
    else if (dp_mix)   dp_vc = mix_cols(dp_vb, dp_inv);
  end

  // ---------------- reference AES-128 ----------------
  function automatic logic [1407:0] expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    logic [1407:0] ks;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = sub_word({t[7:0], t[31:8]}) ^ {24'h0, rc};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 44; i++) ks[32*i +: 32] = w[i];
    return ks;
  endfunction

  function automatic logic [127:0] ref_enc(input logic [127:0] key, input logic [127:0] pt);
    logic [1407:0] ks;
    logic [127:0]  s;
    ks = expand(key);
    s  = pt ^ ks[127:0];
    for (int r = 1; r < 10; r++)
      s = mix_cols(shift_rows(sub_bytes(s, 1'b0), 1'b0), 1'b0) ^ ks[128*r +: 128];
    return shift_rows(sub_bytes(s, 1'b0), 1'b0) ^ ks[1407:1280];
  endfunction

  function automatic logic [127:0] ref_dec(input logic [127:0] key, input logic [127:0] ct);
    logic [1407:0] ks;
    logic [127:0]  s;
    ks = expand(key);
    s  = ct ^ ks[1407:1280];
    for (int r = 9; r >= 1; r--)
      s = mix_cols(sub_bytes(shift_rows(s, 1'b1), 1'b1) ^ ks[128*r +: 128], 1'b1);
    return sub_bytes(shift_rows(s, 1'b1), 1'b1) ^ ks[127:0];
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- per-cycle monitor ----------------
  always @(negedge clk) begin
    if (clrn) begin
      check("op_onehot", 128'($countones({dp_ark, dp_sub, dp_shift, dp_mix}) <= 1), 128'd1);
      check("in_ready_vs_busy", 128'(in_ready), 128'(!busy));
      if (!dp_ark) check("dp_a_zero", 128'(dp_a), 128'd0);
      else ark_q.push_back(dp_a);
      if (!busy) check("idle_dp_zero", {dp_vb[123:0], dp_ark, dp_sub, dp_shift, dp_mix}, 128'd0);
      if (dp_ark || dp_sub || dp_shift || dp_mix) op_cycles++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    clrn = 1'b0;
    repeat (3) @(negedge clk);
    clrn = 1'b1;
    model_kv = 1'b0;
  endtask

  task automatic do_req(input logic dec, input logic kl, input logic [127:0] key,
                        input logic [127:0] data, input int hold);
    logic expand_now;
    logic [127:0] exp_out, held;
    int exp_lat, lat, w;
    expand_now = kl || !model_kv;
    if (expand_now) begin model_key = key; model_kv = 1'b1; end
    exp_out = dec ? ref_dec(model_key, data) : ref_enc(model_key, data);
    exp_q.push_back(exp_out);
    exp_lat = expand_now ? 40 : 30;

    @(negedge clk);
    out_ready = (hold == 0);
    in_valid = 1'b1; in_dec = dec; in_key_load = kl; in_key = key; in_data = data;
    w = 0;
    while (!in_ready && w < 100) begin @(negedge clk); w++; end
    check("accept_ready", 128'(in_ready), 128'd1);
    ark_q.delete();
    op_cycles = 0;
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_key = rnd128(); in_data = rnd128(); in_key_load = $urandom_range(0, 1);

    lat = 0;
    while (lat < 200) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (out_valid) break;
    end
    check("latency", 128'(lat), 128'(exp_lat));
    check("out_valid", 128'(out_valid), 128'd1);
    check("out_data", out_data, exp_q.pop_front());
    check("op_cycles", 128'(op_cycles), 128'(exp_lat - 1));
    check("ark_count", 128'(ark_q.size()), expand_now ? 128'd10 : 128'd0);
    if (expand_now && ark_q.size() == 10)
      for (int i = 0; i < 10; i++) check("rcon_seq", 128'(ark_q[i]), 128'(rcon_exp[i]));

    held = out_data;
    for (int i = 0; i < hold; i++) begin
      in_valid = i[0]; in_dec = $urandom_range(0, 1); in_data = rnd128();
      @(posedge clk); @(negedge clk);
      check("bp_valid", 128'(out_valid), 128'd1);
      check("bp_data", out_data, held);
      check("bp_in_ready", 128'(in_ready), 128'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    check("done_exit_valid", 128'(out_valid), 128'd0);
    check("done_exit_ready", 128'(in_ready), 128'd1);
    check("done_exit_busy", 128'(busy), 128'd0);
  endtask

  // ---------------- main sequence ----------------
  localparam logic [127:0] FIPS_KEY = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] FIPS_PT  = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] FIPS_CT  = 128'h5ac5b47080b7cdd830047b6ad8e0c469;

  initial begin
    logic [7:0] rc;
    logic [1407:0] ks;
    in_valid = 1'b0; in_dec = 1'b0; in_key_load = 1'b0;
    in_key = '0; in_data = '0; out_ready = 1'b1;
    clrn = 1'b0; model_kv = 1'b0; model_key = '0; op_cycles = 0;
    build_sbox();
    rc = 8'h01;
    for (int i = 0; i < 10; i++) begin rcon_exp.push_back({24'h0, rc}); rc = xt(rc); end

    // Reference model against the published vector.
    ks = expand(FIPS_KEY);
    check("ref_rk10", ks[1407:1280], 128'hc5302b4d8ba707f3174a94e37f1d1113);
    check("ref_enc", ref_enc(FIPS_KEY, FIPS_PT), FIPS_CT);

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_in_ready", 128'(in_ready), 128'd1);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_out_data", out_data, 128'd0);
    check("rst_dp", {dp_vb[94:0], dp_a, dp_ark, dp_sub, dp_shift, dp_mix, dp_inv}, 128'd0);
    clrn = 1'b1;

    // First request after reset without key_load still expands.
    do_req(1'b0, 1'b0, FIPS_KEY, FIPS_PT, 0);
    // Forced re-expansion with key_valid set.
    do_req(1'b0, 1'b1, FIPS_KEY, FIPS_PT, 0);
    // Cached-key decrypt.
    do_req(1'b1, 1'b0, rnd128(), FIPS_CT, 0);
    // Backpressure for 5 cycles.
    do_req(1'b0, 1'b0, rnd128(), rnd128(), 5);

    // Random traffic.
    for (int t = 0; t < 12; t++)
      do_req(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), rnd128(), rnd128(),
             int'($urandom_range(0, 3)));

    // Abort in the middle of RND (cached key: INIT then RND cycle 12).
    @(negedge clk);
    in_valid = 1'b1; in_dec = 1'b0; in_key_load = 1'b0; in_key = rnd128(); in_data = rnd128();
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (13) @(posedge clk);
    @(negedge clk);
    check("abort_busy_before", 128'(busy), 128'd1);
    clrn = 1'b0;
    #1;
    check("abort_in_ready", 128'(in_ready), 128'd1);
    check("abort_out_valid", 128'(out_valid), 128'd0);
    check("abort_busy", 128'(busy), 128'd0);
    check("abort_dp", {dp_vb[94:0], dp_a, dp_ark, dp_sub, dp_shift, dp_mix, dp_inv}, 128'd0);
    repeat (2) @(negedge clk);
    clrn = 1'b1;
    model_kv = 1'b0;
    // Next request must expand the new key despite key_load=0.
    do_req(1'b1, 1'b0, rnd128(), rnd128(), 0);
    do_req(1'b0, 1'b0, rnd128(), rnd128(), 1);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
